prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 15 +
 rtl/prog_loader_if.sv | 29 ++
 rtl/prog_loader_word_packer.sv | 42 ++++
 rtl/prog_loader.sv | 125 ++++++++++++
 tb/tb_prog_loader.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_loader_pkg.sv
// Shared loader types: FSM state enum and the sync byte value.
// No ports; imported by the loader RTL.
package common;

   typedef enum logic [2:0] {
      IDLE,
      LEN,
      DATA,
      DONE,
      ERROR
   } loader_state_t;

   localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-in / program-memory-out bundle of the program loader.
// master: byte source and memory side; slave: the loader itself.
interface prog_loader_if;

   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        pmem_write_enable;
   logic [31:0] pmem_byte_address;
   logic [31:0] pmem_write_data;
   logic        cpu_reset_n;
   logic        busy;
   logic        done;
   logic        error;

   modport master (
      output rx_valid, rx_data,
      input  pmem_write_enable, pmem_byte_address,
      input  pmem_write_data, cpu_reset_n,
      input  busy, done, error
   );

   modport slave (
      input  rx_valid, rx_data,
      output pmem_write_enable, pmem_byte_address,
      output pmem_write_data, cpu_reset_n,
      output busy, done, error
   );

endinterface

// File: rtl/prog_loader_word_packer.sv
// Little-endian byte-to-word packer used for length and data words.
// Ports: clk, reset, clear_i, valid_i, byte_i -> word_o, ready_o.
module word_packer (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear_i,
   input  logic        valid_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        ready_o
);

   logic [23:0] sr_q, sr_d;
   logic [1:0]  cnt_q, cnt_d;

   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      if (clear_i) begin
         sr_d  = '0;
         cnt_d = '0;
      end else if (valid_i) begin
         sr_d  = {byte_i, sr_q[23:8]};
         cnt_d = cnt_q + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
      end
   end

   // Word is complete in the same cycle as its 4th byte.
   assign word_o  = {byte_i, sr_q};
   assign ready_o = valid_i & ~clear_i & (cnt_q == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: sync byte, 32-bit length, then words.
// Ports: clk, reset, bus (slave): rx in, pmem write + status out.
module prog_loader
   import common::*;
#(
   parameter int unsigned MAX_WORDS      = 1024,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input logic         clk,
   input logic         reset,
   prog_loader_if.slave bus
);

   localparam int unsigned IW = $clog2(MAX_WORDS) + 1;
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   loader_state_t state_q, state_d;
   logic [31:0]   wcount_q, wcount_d;
   logic [IW-1:0] widx_q, widx_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          we_q, we_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   data_q, data_d;

   logic          busy_w;
   logic          tmo_hit;
   logic          pk_ready;
   logic [31:0]   pk_word;

   assign busy_w = (state_q == LEN) || (state_q == DATA);

   // A byte arriving on the expiry cycle wins over the timeout.
   assign tmo_hit = busy_w & ~bus.rx_valid &
                    (tmo_q == TW'(TIMEOUT_CYCLES - 1));

   word_packer u_pack (
      .clk     (clk),
      .reset   (reset),
      .clear_i (~busy_w),
      .valid_i (bus.rx_valid & busy_w),
      .byte_i  (bus.rx_data),
      .word_o  (pk_word),
      .ready_o (pk_ready)
   );

   always_comb begin
      state_d  = state_q;
      wcount_d = wcount_q;
      widx_d   = widx_q;
      we_d     = 1'b0;
      addr_d   = addr_q;
      data_d   = data_q;
      unique case (state_q)
         IDLE, ERROR: begin
            if (bus.rx_valid &&
                bus.rx_data == LOADER_SYNC_BYTE)
               state_d = LEN;
         end
         LEN: begin
            if (tmo_hit) begin
               state_d = ERROR;
            end else if (pk_ready) begin
               wcount_d = pk_word;
               if (pk_word == '0 || pk_word > MAX_WORDS) begin
                  state_d = ERROR;
               end else begin
                  state_d = DATA;
                  widx_d  = '0;
               end
            end
         end
         DATA: begin
            if (tmo_hit) begin
               state_d = ERROR;
            end else if (pk_ready) begin
               we_d   = 1'b1;
               addr_d = 32'(widx_q) << 2;
               data_d = pk_word;
               widx_d = widx_q + IW'(1);
               if (32'(widx_q) + 32'd1 == wcount_q)
                  state_d = DONE;
            end
         end
         DONE: begin
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      if (!busy_w || bus.rx_valid || state_d != state_q)
         tmo_d = '0;
      else
         tmo_d = tmo_q + TW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         wcount_q <= '0;
         widx_q   <= '0;
         tmo_q    <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         wcount_q <= wcount_d;
         widx_q   <= widx_d;
         tmo_q    <= tmo_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
      end
   end

   assign bus.pmem_write_enable = we_q;
   assign bus.pmem_byte_address = addr_q;
   assign bus.pmem_write_data   = data_q;
   assign bus.cpu_reset_n       = (state_q == DONE);
   assign bus.busy              = busy_w;
   assign bus.done              = (state_q == DONE);
   assign bus.error             = (state_q == ERROR);

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table vectors, corner
// sequences and random streams against a byte-stream model.
module tb_prog_loader;

   localparam int MAXW = 1024;
   localparam int TO   = 8;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;
   int   ntests = 0;
   int   nfail  = 0;

   prog_loader_if bus();

   prog_loader #(
      .MAX_WORDS      (MAXW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      int          c;
      logic        dn;
   } wr_t;

   wr_t wq[$];
   wr_t eq[$];

   always @(negedge clk)
      if (bus.pmem_write_enable === 1'b1)
         wq.push_back('{bus.pmem_byte_address,
                        bus.pmem_write_data, cyc, bus.done});

   logic [7:0] sb[$];
   int         sg[$];
   int         st[$];

   typedef logic [7:0] bq_t[$];

   typedef struct {
      int          gpos;
      int          glen;
      int          nw;
      int          ix0;
      int          ix1;
      logic [31:0] d0;
      logic [31:0] d1;
      logic        dn;
      logic        er;
   } vec_t;

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, expected %0h",
                  nm, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      @(negedge clk);
      reset = 1'b0;
      wq.delete();
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      @(negedge clk);
      bus.rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      @(posedge clk);
      #1;
      st.push_back(cyc);
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      bus.rx_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic play();
      st.delete();
      for (int i = 0; i < sb.size(); i++)
         send(sb[i], sg[i]);
      idle(20);
   endtask

   // Stream model: 0 idle, 1 len, 2 data, 3 done, 4 error.
   task automatic model(output int fin);
      int mode = 0;
      int prev = 0;
      int widx = 0;
      logic [7:0]  q[$];
      logic [31:0] wc = 0;
      logic [31:0] w;
      eq.delete();
      for (int i = 0; i < sb.size(); i++) begin
         if ((mode == 1 || mode == 2) &&
             (st[i] - prev - 1 >= TO)) begin
            mode = 4;
            q.delete();
         end
         prev = st[i];
         case (mode)
            0, 4: if (sb[i] == 8'hA5) begin
               mode = 1;
               q.delete();
            end
            1: begin
               q.push_back(sb[i]);
               if (q.size() == 4) begin
                  wc = {q[3], q[2], q[1], q[0]};
                  q.delete();
                  if (wc == 0 || wc > MAXW) mode = 4;
                  else begin
                     mode = 2;
                     widx = 0;
                  end
               end
            end
            2: begin
               q.push_back(sb[i]);
               if (q.size() == 4) begin
                  w = {q[3], q[2], q[1], q[0]};
                  q.delete();
                  eq.push_back('{32'(widx * 4), w, st[i],
                                 (widx == int'(wc) - 1)});
                  widx++;
                  if (widx == int'(wc)) mode = 3;
               end
            end
            default: ;
         endcase
      end
      if (mode == 1 || mode == 2) mode = 4;
      fin = mode;
   endtask

   task automatic check_writes(input string nm);
      chk({nm, ".nwr"}, 64'(wq.size()), 64'(eq.size()));
      for (int i = 0; i < eq.size() && i < wq.size(); i++) begin
         chk($sformatf("%s.a%0d", nm, i), 64'(wq[i].a), 64'(eq[i].a));
         chk($sformatf("%s.d%0d", nm, i), 64'(wq[i].d), 64'(eq[i].d));
         chk($sformatf("%s.t%0d", nm, i), 64'(wq[i].c), 64'(eq[i].c));
         chk($sformatf("%s.dn%0d", nm, i), 64'(wq[i].dn), 64'(eq[i].dn));
      end
   endtask

   task automatic check_flags(input string nm,
                              input logic dn,
                              input logic er);
      chk({nm, ".done"}, 64'(bus.done), 64'(dn));
      chk({nm, ".error"}, 64'(bus.error), 64'(er));
      chk({nm, ".busy"}, 64'(bus.busy), 64'd0);
      chk({nm, ".crn"}, 64'(bus.cpu_reset_n), 64'(dn));
   endtask

   bq_t  vb[10];
   vec_t vt[10];

   initial begin
      int fin;
      int nb;
      int wc;
      logic [7:0] b;

      vb[0] = '{8'h11, 8'hA5, 8'h02, 8'h00, 8'h00, 8'h00,
                8'h13, 8'h00, 8'h00, 8'h00,
                8'h93, 8'h00, 8'h10, 8'h00};
      vt[0] = '{-1, 0, 2, 9, 13, 32'h13, 32'h00100093, 1, 0};
      vb[1] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
      vt[1] = '{-1, 0, 0, 0, 0, 0, 0, 0, 1};
      vb[2] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00,
                8'hA5, 8'h01, 8'h00, 8'h00, 8'h00,
                8'hEF, 8'hBE, 8'hAD, 8'hDE};
      vt[2] = '{-1, 0, 1, 13, 0, 32'hDEADBEEF, 0, 1, 0};
      vb[3] = '{8'hA5, 8'h01, 8'h04, 8'h00, 8'h00};
      vt[3] = '{-1, 0, 0, 0, 0, 0, 0, 0, 1};
      vb[4] = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00,
                8'h11, 8'h22};
      vt[4] = '{-1, 0, 0, 0, 0, 0, 0, 0, 1};
      vb[5] = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00,
                8'h11, 8'h22, 8'h33, 8'h44};
      vt[5] = '{7, 7, 1, 8, 0, 32'h44332211, 0, 1, 0};
      vb[6] = vb[5];
      vt[6] = '{7, 8, 0, 0, 0, 0, 0, 0, 1};
      vb[7] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h12, 8'h34,
                8'hA5, 8'h01, 8'h00, 8'h00, 8'h00,
                8'h01, 8'h02, 8'h03, 8'h04};
      vt[7] = '{-1, 0, 1, 15, 0, 32'h04030201, 0, 1, 0};
      vb[8] = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00,
                8'h01, 8'h02, 8'h03, 8'h04,
                8'hA5, 8'h01, 8'h00, 8'h00, 8'h00,
                8'h05, 8'h06, 8'h07, 8'h08};
      vt[8] = '{-1, 0, 1, 8, 0, 32'h04030201, 0, 1, 0};
      vb[9] = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00,
                8'h11, 8'h22, 8'h33, 8'h44};
      vt[9] = '{3, 8, 0, 0, 0, 0, 0, 0, 1};

      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;

      // Reset state.
      do_reset();
      chk("rst.we", 64'(bus.pmem_write_enable), 64'd0);
      chk("rst.addr", 64'(bus.pmem_byte_address), 64'd0);
      chk("rst.data", 64'(bus.pmem_write_data), 64'd0);
      check_flags("rst", 1'b0, 1'b0);

      // Table vectors.
      for (int k = 0; k < 10; k++) begin
         do_reset();
         sb = vb[k];
         sg.delete();
         for (int i = 0; i < sb.size(); i++)
            sg.push_back(i == vt[k].gpos ? vt[k].glen : 0);
         play();
         eq.delete();
         if (vt[k].nw > 0)
            eq.push_back('{32'h0, vt[k].d0, st[vt[k].ix0],
                           vt[k].nw == 1});
         if (vt[k].nw > 1)
            eq.push_back('{32'h4, vt[k].d1, st[vt[k].ix1],
                           1'b1});
         check_writes($sformatf("vec%0d", k));
         check_flags($sformatf("vec%0d", k), vt[k].dn, vt[k].er);
      end

      // Reset after first of three words.
      do_reset();
      sb = '{8'hA5, 8'h03, 8'h00, 8'h00, 8'h00,
             8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      st.delete();
      for (int i = 0; i < sb.size(); i++) send(sb[i], 0);
      @(negedge clk);
      bus.rx_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("mid.we", 64'(bus.pmem_write_enable), 64'd0);
      chk("mid.addr", 64'(bus.pmem_byte_address), 64'd0);
      chk("mid.data", 64'(bus.pmem_write_data), 64'd0);
      chk("mid.crn", 64'(bus.cpu_reset_n), 64'd0);
      chk("mid.busy", 64'(bus.busy), 64'd0);
      chk("mid.done", 64'(bus.done), 64'd0);
      chk("mid.error", 64'(bus.error), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      send(8'h77, 0);
      send(8'h88, 0);
      idle(20);
      chk("mid.nwr", 64'(wq.size()), 64'd1);
      if (wq.size() > 0)
         chk("mid.d0", 64'(wq[0].d), 64'h44332211);
      check_flags("mid", 1'b0, 1'b0);

      // Full-capacity load.
      do_reset();
      sb = '{8'hA5, 8'h00, 8'h04, 8'h00, 8'h00};
      for (int i = 0; i < 4 * MAXW; i++)
         sb.push_back(8'((i * 7 + 3) & 255));
      sg.delete();
      for (int i = 0; i < sb.size(); i++) sg.push_back(0);
      play();
      model(fin);
      check_writes("full");
      check_flags("full", fin == 3, fin == 4);
      if (wq.size() > 0)
         chk("full.last", 64'(wq[wq.size() - 1].a), 64'hFFC);

      // Random streams.
      for (int r = 0; r < 30; r++) begin
         do_reset();
         sb.delete();
         sg.delete();
         repeat ($urandom_range(2)) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h5A;
            sb.push_back(b);
            sg.push_back($urandom_range(2));
         end
         sb.push_back(8'hA5);
         sg.push_back($urandom_range(2));
         case ($urandom_range(9))
            0: wc = 0;
            1: wc = MAXW + 1;
            default: wc = $urandom_range(5, 1);
         endcase
         for (int i = 0; i < 4; i++) begin
            sb.push_back(8'((wc >> (8 * i)) & 255));
            sg.push_back($urandom_range(2));
         end
         nb = (wc >= 1 && wc <= 5) ? wc * 4 : 8;
         if ($urandom_range(4) == 0) nb = $urandom_range(nb);
         if ($urandom_range(2) == 0) nb += 9;
         for (int i = 0; i < nb; i++) begin
            sb.push_back(8'($urandom));
            if ($urandom_range(11) == 0)
               sg.push_back($urandom_range(9, 7));
            else
               sg.push_back($urandom_range(2));
         end
         if ($urandom_range(2) == 0) begin
            sb.push_back(8'hA5);
            sg.push_back(0);
            sb.push_back(8'h01);
            sg.push_back(0);
            for (int i = 0; i < 7; i++) begin
               sb.push_back(i < 3 ? 8'h00 : 8'($urandom));
               sg.push_back($urandom_range(1));
            end
         end
         play();
         model(fin);
         check_writes($sformatf("rnd%0d", r));
         check_flags($sformatf("rnd%0d", r), fin == 3, fin == 4);
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
